// File: rtl/ioctl_rom_router.sv
// ioctl_rom_router: routes hps_io ioctl downloads into per-region ROM write
// ports, captures DIP and game-mod bytes, tracks load completion and
// stretches the core reset across downloads.
module ioctl_rom_router #(
    parameter int                          NUM_REGIONS = 3,
    parameter int                          RGN_AW      = 16,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE = {32'h0000FF00, 32'h0000E000, 32'h00000000},
    parameter logic [NUM_REGIONS*32-1:0]   REGION_END  = {32'h00010000, 32'h0000F000, 32'h00008000},
    parameter logic [7:0]                  ROM_INDEX   = 8'd0,
    parameter logic [7:0]                  MOD_INDEX   = 8'd1,
    parameter logic [7:0]                  DIP_INDEX   = 8'd254,
    parameter int                          DIP_BYTES   = 8,
    parameter int                          NUM_MODS    = 5,
    parameter int                          RESET_HOLD  = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic [NUM_REGIONS-1:0]   rgn_we,
    output logic [RGN_AW-1:0]        rgn_addr,
    output logic [7:0]               rgn_data,
    output logic [NUM_REGIONS-1:0]   rgn_loaded,
    output logic                     dl_done,
    output logic                     dl_error,
    output logic [DIP_BYTES*8-1:0]   dip_sw,
    output logic [NUM_MODS-1:0]      mod_onehot,
    output logic                     mod_valid,
    output logic                     core_reset_out
);

    localparam int CNT_W = $clog2(RESET_HOLD + 1);

    logic [31:0]            addr_ext;
    logic                   rom_wr;
    logic                   dl_rise;
    logic                   dl_start;
    logic                   dl_end;
    logic [NUM_REGIONS-1:0] match;
    logic [NUM_REGIONS-1:0] last_hit;
    logic [RGN_AW-1:0]      local_addr [NUM_REGIONS];
    logic [RGN_AW-1:0]      sel_addr;
    logic [NUM_REGIONS-1:0] loaded_next;
    logic                   error_next;

    logic [NUM_REGIONS-1:0] rgn_we_reg;
    logic [RGN_AW-1:0]      rgn_addr_reg;
    logic [7:0]             rgn_data_reg;
    logic [NUM_REGIONS-1:0] rgn_loaded_reg;
    logic                   dl_done_reg;
    logic                   dl_error_reg;
    logic                   prev_dl_reg;
    logic                   rom_session_reg;
    logic [CNT_W-1:0]       hold_cnt_reg;
    logic                   core_reset_reg;

    // Configuration state survives resets, so it carries power-up values only.
    logic [DIP_BYTES*8-1:0] dip_reg        = '0;
    logic [7:0]             mod_byte_reg   = '0;
    logic [NUM_MODS-1:0]    mod_onehot_reg = NUM_MODS'(1);
    logic                   mod_valid_reg  = 1'b1;
    logic [NUM_MODS-1:0]    mod_onehot_next;

    assign addr_ext = {7'd0, ioctl_addr};
    assign rom_wr   = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
    assign dl_rise  = ioctl_download && !prev_dl_reg;
    assign dl_start = dl_rise && (ioctl_index == ROM_INDEX);
    assign dl_end   = !ioctl_download && prev_dl_reg && rom_session_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_rgn
            localparam logic [31:0] BASE  = REGION_BASE[gi*32 +: 32];
            localparam logic [31:0] END_A = REGION_END[gi*32 +: 32];
            localparam logic [31:0] LAST  = END_A - 32'd1;
            assign match[gi]      = (addr_ext >= BASE) && (addr_ext < END_A);
            assign last_hit[gi]   = rom_wr && (addr_ext == LAST);
            assign local_addr[gi] = RGN_AW'(addr_ext - BASE);
        end
    endgenerate

    // Lowest-numbered matching region supplies the rebased address.
    always_comb begin
        sel_addr = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_addr = local_addr[i];
            end
        end
    end

    // A download start clears the flags, but a same-cycle last-byte write still sets.
    always_comb begin
        loaded_next = (dl_start ? '0 : rgn_loaded_reg) | last_hit;
        error_next  = (dl_start ? 1'b0 : dl_error_reg) | (rom_wr && (match == '0));
    end

    // ROM routing, load tracking and download edge detection.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgn_we_reg      <= '0;
            rgn_addr_reg    <= '0;
            rgn_data_reg    <= '0;
            rgn_loaded_reg  <= '0;
            dl_done_reg     <= 1'b0;
            dl_error_reg    <= 1'b0;
            prev_dl_reg     <= 1'b0;
            rom_session_reg <= 1'b0;
        end else begin
            rgn_we_reg <= rom_wr ? match : '0;
            if (rom_wr && (match != '0)) begin
                rgn_addr_reg <= sel_addr;
                rgn_data_reg <= ioctl_dout;
            end
            rgn_loaded_reg <= loaded_next;
            dl_error_reg   <= error_next;
            dl_done_reg    <= dl_end && (&loaded_next) && !error_next;
            prev_dl_reg    <= ioctl_download;
            if (dl_rise) begin
                rom_session_reg <= (ioctl_index == ROM_INDEX);
            end
        end
    end

    // DIP byte capture; out-of-range addresses match no byte lane.
    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < DIP_BYTES; i++) begin
            if (ioctl_wr && (ioctl_index == DIP_INDEX) && (addr_ext == 32'(i))) begin
                dip_reg[i*8 +: 8] <= ioctl_dout;
            end
        end
    end

    // Mod byte latch; the last write wins.
    always_ff @(posedge clk_sys) begin
        if (ioctl_wr && (ioctl_index == MOD_INDEX)) begin
            mod_byte_reg <= ioctl_dout;
        end
    end

    // One-hot decode of the latched mod byte; out-of-range bytes decode to zero.
    always_comb begin
        mod_onehot_next = '0;
        for (int i = 0; i < NUM_MODS; i++) begin
            if (mod_byte_reg == 8'(i)) begin
                mod_onehot_next[i] = 1'b1;
            end
        end
    end

    // Registered mod outputs, one cycle behind the latch.
    always_ff @(posedge clk_sys) begin
        mod_onehot_reg <= mod_onehot_next;
        mod_valid_reg  <= (mod_byte_reg < 8'(NUM_MODS));
    end

    // Core reset stretcher: any source reloads the hold counter.
    always_ff @(posedge clk_sys) begin
        if (reset || ioctl_download) begin
            hold_cnt_reg   <= CNT_W'(RESET_HOLD);
            core_reset_reg <= 1'b1;
        end else if (hold_cnt_reg != '0) begin
            hold_cnt_reg   <= hold_cnt_reg - CNT_W'(1);
            core_reset_reg <= 1'b1;
        end else begin
            core_reset_reg <= 1'b0;
        end
    end

    assign rgn_we         = rgn_we_reg;
    assign rgn_addr       = rgn_addr_reg;
    assign rgn_data       = rgn_data_reg;
    assign rgn_loaded     = rgn_loaded_reg;
    assign dl_done        = dl_done_reg;
    assign dl_error       = dl_error_reg;
    assign dip_sw         = dip_reg;
    assign mod_onehot     = mod_onehot_reg;
    assign mod_valid      = mod_valid_reg;
    assign core_reset_out = core_reset_reg;

endmodule
